instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, which is the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port next_pc, input, 32 bits: the next PC computed by the pc_branch stage (PC+4 or branch target).
REQ-005 SHALL have port pc, output, 32 bits: the current PC register, fed to pc_branch pc_in.
REQ-006 SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-007 SHALL have port imem_addr, output, 32 bits: the read address, equal to pc.
REQ-008 SHALL have port imem_ack, input, 1 bit: memory completion strobe; imem_rdata is valid in the same cycle.
REQ-009 SHALL have port imem_rdata, input, 32 bits: the fetched instruction word.
REQ-010 SHALL have port instr, output, 32 bits: the held instruction register.
REQ-011 SHALL have port imm16, output, 16 bits: always instr[15:0], driven to pc_branch imm16.
REQ-012 SHALL have port instr_valid, output, 1 bit: instr holds an unconsumed instruction.
REQ-013 SHALL have port instr_ready, input, 1 bit: the decode/execute stage accepts instr.
REQ-014 SHALL have port stall, input, 1 bit: blocks acceptance and PC update.
REQ-015 SHALL have port fault, output, 1 bit: sticky misaligned-PC error flag.
REQ-016 SHALL have port retired, output, 32 bits: count of accepted instructions.

Function
REQ-017 SHALL implement the states BOOT, FETCH, VALID and ERROR.
REQ-018 In BOOT, the block SHALL hold all outputs at their reset values for exactly one cycle, then enter FETCH.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack.
REQ-020 On imem_ack in FETCH: instr <= imem_rdata, instr_valid <= 1, state <= VALID, and imem_req SHALL be 0 from the next cycle.
REQ-021 In FETCH, stall SHALL NOT abort an outstanding request; the request completes normally.
REQ-022 Latency SHALL be fixed: imem_ack in cycle N gives instr_valid=1 in cycle N+1.
REQ-023 Acceptance SHALL occur in VALID when instr_valid && instr_ready && !stall.
REQ-024 On acceptance: pc <= next_pc; instr_valid <= 0; retired <= retired+1 (mod 2^32, wraps to 0); state <= FETCH; imem_req=1 with the new pc in the next cycle.
REQ-025 In VALID without acceptance, instr, pc and instr_valid SHALL be held unchanged for any number of cycles.
REQ-026 instr SHALL change only on imem_ack in FETCH; imem_ack in any other state SHALL be ignored.
REQ-027 Misaligned next_pc: if acceptance occurs with next_pc[1:0] != 0, then pc <= next_pc, fault <= 1, retired still increments, state <= ERROR.
REQ-028 In ERROR, the block SHALL hold imem_req=0 and instr_valid=0 and leave all registers frozen until reset.
REQ-029 pc SHALL be updated only by reset (to RESET_PC) or by acceptance.
REQ-030 The FSM SHALL never produce imem_req and instr_valid both equal to 1 in the same cycle.

Reset
REQ-031 When rst_n=0, the block SHALL immediately, independent of clk, set: state=BOOT, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, fault=0, retired=0.
REQ-032 Reset mid-fetch SHALL drop imem_req asynchronously; an imem_ack arriving during reset or during BOOT SHALL be discarded.
REQ-033 Deassertion of rst_n SHALL be sampled on a clk edge; the first request SHALL appear in the second cycle after deassertion.

Verification
REQ-034 Scenario: release reset, ack after 0 wait cycles with rdata=32'h2002_0005, hold ready=1 and next_pc=pc+4 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; retired increments by 1 per instruction.
REQ-035 Scenario: ack delayed 3 cycles with stall=1 during the wait -> imem_req stays high with a stable address; instr_valid rises exactly one cycle after ack.
REQ-036 Scenario: instr_valid=1 with instr_ready=0 for 5 cycles, then ready=1 and next_pc=0x00400020 -> instr and pc held during the wait; the next imem_addr is 0x00400020.
REQ-037 Scenario: accept with next_pc=0x00400006 -> fault=1, pc=0x00400006, and imem_req=0 permanently until rst_n is pulsed.
REQ-038 Scenario: rst_n pulsed low while imem_req=1, with ack arriving in the reset cycle -> all outputs return to reset values asynchronously, instr=0, and the fetch restarts at RESET_PC.
REQ-039 Scenario: retired preloaded near 32'hFFFF_FFFF (via 2^32-1 forced value), one acceptance -> retired=0 and no other side effects.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and pc_branch links.
// master = instr_fetch itself, slave = the surrounding core / memory.
interface instr_fetch_if;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [15:0] imm16;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        fault;
    logic [31:0] retired;

    modport master (
        input  next_pc, imem_ack, imem_rdata, instr_ready, stall,
        output pc, imem_req, imem_addr, instr, imm16, instr_valid, fault, retired
    );

    modport slave (
        output next_pc, imem_ack, imem_rdata, instr_ready, stall,
        input  pc, imem_req, imem_addr, instr, imm16, instr_valid, fault, retired
    );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage: holds PC and the fetched word,
// hands it to decode, counts retirements and locks up on a misaligned PC.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_fetch_if.master  bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERROR = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fault_q, fault_d;
    logic        boot_q, boot_d;

    // Next-state and register-update logic for the fetch FSM
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        retired_d     = retired_q;
        imem_req_d    = imem_req_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        boot_d        = boot_q;
        case (state_q)
            BOOT: begin
                // First edge after reset release only arms boot_q, so BOOT spans one full cycle
                if (boot_q) begin
                    state_d    = FETCH;
                    imem_req_d = 1'b1;
                end else begin
                    boot_d     = 1'b1;
                end
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d       = bus.imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = VALID;
                end else begin
                    imem_req_d    = 1'b1;
                end
            end
            VALID: begin
                if (instr_valid_q && bus.instr_ready && !bus.stall) begin
                    pc_d          = bus.next_pc;
                    instr_valid_d = 1'b0;
                    retired_d     = retired_q + 32'd1;
                    if (bus.next_pc[1:0] != 2'b00) begin
                        fault_d    = 1'b1;
                        imem_req_d = 1'b0;
                        state_d    = ERROR;
                    end else begin
                        imem_req_d = 1'b1;
                        state_d    = FETCH;
                    end
                end else begin
                    state_d = VALID;
                end
            end
            ERROR: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
            default: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                state_d       = ERROR;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            retired_q     <= 32'h0000_0000;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            boot_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            boot_q        <= boot_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.imm16       = instr_q[15:0];
    assign bus.instr_valid = instr_valid_q;
    assign bus.fault       = fault_q;
    assign bus.retired     = retired_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; inputs change and outputs are
// sampled on the falling clock edge.
module tb_instr_fetch;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(32'h0040_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.next_pc = 32'd0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
        bus.instr_ready = 1'b0; bus.stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.pc !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc got %h want %h", bus.pc, 32'h0040_0000); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
        checks++; if (bus.instr !== 32'd0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr got %h/%b want 0/0", bus.instr, bus.instr_valid); end
        checks++; if (bus.fault !== 1'b0 || bus.retired !== 32'd0) begin errors++; $display("FAIL reset_fault_ret got %b/%h want 0/0", bus.fault, bus.retired); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b want 0", bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL first_req got %b/%h want 1/00400000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] exp_pc;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h0040_0000 + 32'd4 * i;
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin errors++; $display("FAIL basic_addr[%0d] got %b/%h want 1/%h", i, bus.imem_req, bus.imem_addr, exp_pc); end
            bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2002_0005; bus.instr_ready = 1'b1;
            tick();
            bus.imem_ack = 1'b0;
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h2002_0005 || bus.imm16 !== 16'h0005 || bus.imem_req !== 1'b0) begin
                errors++; $display("FAIL basic_valid[%0d] got v=%b instr=%h imm=%h req=%b want 1/20020005/0005/0", i, bus.instr_valid, bus.instr, bus.imm16, bus.imem_req); end
            bus.next_pc = exp_pc + 32'd4;
            tick();
            checks++; if (bus.retired !== 32'(i + 1) || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_retired[%0d] got %h/%b want %h/0", i, bus.retired, bus.instr_valid, 32'(i + 1)); end
        end
        checks++; if (bus.imem_addr !== 32'h0040_000C || bus.imem_req !== 1'b1) begin errors++; $display("FAIL basic_final_addr got %h want 0040000c", bus.imem_addr); end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_stall_during_fetch();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_000C || bus.instr_valid !== 1'b0) begin
                errors++; $display("FAIL stall_wait[%0d] got req=%b addr=%h v=%b want 1/0040000c/0", i, bus.imem_req, bus.imem_addr, bus.instr_valid); end
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8C41_1234;
        tick();
        bus.imem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h8C41_1234 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_ack got v=%b instr=%h req=%b want 1/8c411234/0", bus.instr_valid, bus.instr, bus.imem_req); end
        bus.instr_ready = 1'b1; bus.next_pc = 32'h0040_0010;
        tick();
        checks++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h0040_000C || bus.retired !== 32'd3) begin
            errors++; $display("FAIL stall_blocks_accept got v=%b pc=%h ret=%h want 1/0040000c/3", bus.instr_valid, bus.pc, bus.retired); end
        bus.stall = 1'b0; bus.instr_ready = 1'b0;
    endtask

    task automatic test_ready_hold();
        bus.next_pc = 32'h0040_0020;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h8C41_1234 || bus.pc !== 32'h0040_000C || bus.imem_req !== 1'b0) begin
                errors++; $display("FAIL hold[%0d] got v=%b instr=%h pc=%h req=%b want 1/8c411234/0040000c/0", i, bus.instr_valid, bus.instr, bus.pc, bus.imem_req); end
        end
        bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0020 || bus.retired !== 32'd4) begin
            errors++; $display("FAIL hold_branch got req=%b addr=%h ret=%h want 1/00400020/4", bus.imem_req, bus.imem_addr, bus.retired); end
    endtask

    task automatic test_retired_wrap();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
        tick();
        bus.imem_ack = 1'b0;
        force dut.retired_q = 32'hFFFF_FFFF;
        tick();
        release dut.retired_q;
        #1;
        checks++; if (bus.retired !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h want ffffffff", bus.retired); end
        @(negedge clk);
        bus.instr_ready = 1'b1; bus.next_pc = 32'h0040_0024;
        tick();
        bus.instr_ready = 1'b0;
        checks++; if (bus.retired !== 32'd0 || bus.pc !== 32'h0040_0024 || bus.fault !== 1'b0 || bus.imem_req !== 1'b1 || bus.instr !== 32'h1234_5678) begin
            errors++; $display("FAIL wrap got ret=%h pc=%h f=%b req=%b instr=%h want 0/00400024/0/1/12345678", bus.retired, bus.pc, bus.fault, bus.imem_req, bus.instr); end
    endtask

    task automatic test_misaligned();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hAAAA_5555;
        tick();
        bus.imem_ack = 1'b0; bus.instr_ready = 1'b1; bus.next_pc = 32'h0040_0006;
        tick();
        checks++; if (bus.fault !== 1'b1 || bus.pc !== 32'h0040_0006 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.retired !== 32'd1) begin
            errors++; $display("FAIL misalign got f=%b pc=%h req=%b v=%b ret=%h want 1/00400006/0/0/1", bus.fault, bus.pc, bus.imem_req, bus.instr_valid, bus.retired); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_0000; bus.next_pc = 32'h0040_0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.imem_req !== 1'b0 || bus.pc !== 32'h0040_0006 || bus.instr !== 32'hAAAA_5555 || bus.retired !== 32'd1 || bus.fault !== 1'b1) begin
                errors++; $display("FAIL error_frozen[%0d] got req=%b pc=%h instr=%h ret=%h f=%b", i, bus.imem_req, bus.pc, bus.instr, bus.retired, bus.fault); end
        end
        bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.fault !== 1'b0 || bus.pc !== 32'h0040_0000 || bus.retired !== 32'd0 || bus.instr !== 32'd0) begin
            errors++; $display("FAIL err_reset got f=%b pc=%h ret=%h instr=%h want 0/00400000/0/0", bus.fault, bus.pc, bus.retired, bus.instr); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL refetch_req got %b/%h want 1/00400000", bus.imem_req, bus.imem_addr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.instr !== 32'd0 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL async_drop got req=%b instr=%h v=%b want 0/0/0", bus.imem_req, bus.instr, bus.instr_valid); end
        @(negedge clk);
        checks++; if (bus.instr !== 32'd0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL ack_in_reset got instr=%h v=%b want 0/0", bus.instr, bus.instr_valid); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.instr !== 32'd0 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL ack_in_boot got instr=%h v=%b req=%b want 0/0/0", bus.instr, bus.instr_valid, bus.imem_req); end
        bus.imem_ack = 1'b0;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0000 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL restart got req=%b addr=%h v=%b want 1/00400000/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0BAD_C0DE;
        tick();
        bus.imem_ack = 1'b0;
        checks++; if (bus.instr !== 32'h0BAD_C0DE || bus.instr_valid !== 1'b1 || bus.imm16 !== 16'hC0DE) begin
            errors++; $display("FAIL restart_fetch got instr=%h v=%b imm=%h want 0badc0de/1/c0de", bus.instr, bus.instr_valid, bus.imm16); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic_fetch();
        test_stall_during_fetch();
        test_ready_hold();
        test_retired_wrap();
        test_misaligned();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
